// File: rtl/ps2_event_decoder.sv
// ps2_event_decoder: folds PS/2 E0/F0/E1 prefixes into atomic key events queued in a FWFT FIFO.
// Define PS2_TYPEMATIC_FILTER_EN to drop auto-repeated makes of the last pressed key.
module ps2_event_decoder #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_ready,
    input  logic [7:0]            scan_code,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [7:0]            ev_code,
    output logic                  ev_ext,
    output logic                  ev_release,
    output logic [DEPTH_LOG2:0]   ev_count,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_PAUSE} state_t;

    state_t                state_q, state_d;
    logic                  ext_q, ext_d;
    logic [2:0]            skip_q, skip_d;
    logic                  dec_push, dec_ext, dec_rel;
    logic [7:0]            dec_code;
    logic                  push, pop, full, wr, drop;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [9:0]            mem_q [DEPTH];
    logic [9:0]            head;
    logic                  is_e0, is_f0, is_e1, is_fake, is_status;

    assign is_e0     = scan_code == 8'hE0;
    assign is_f0     = scan_code == 8'hF0;
    assign is_e1     = scan_code == 8'hE1;
    assign is_fake   = scan_code == 8'h12 || scan_code == 8'h59;
    assign is_status = scan_code inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ext_q   <= 1'b0;
            skip_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            ext_q   <= ext_d;
            skip_q  <= skip_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        skip_d  = skip_q;
        if (scan_ready) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_e0) begin
                        state_d = ST_EXT;
                        ext_d   = 1'b1;
                    end else if (is_f0) begin
                        state_d = ST_BRK;
                        ext_d   = 1'b0;
                    end else if (is_e1) begin
                        state_d = ST_PAUSE;
                        skip_d  = 3'd7;
                    end
                end
                ST_EXT: begin
                    if (is_f0) state_d = ST_BRK;
                    else if (!is_e0) begin
                        state_d = ST_IDLE;
                        ext_d   = 1'b0;
                    end
                end
                ST_BRK: begin
                    if (!is_f0 && !is_e0) begin
                        state_d = ST_IDLE;
                        ext_d   = 1'b0;
                    end
                end
                default: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Decoded event for this strobe; the Pause sequence collapses to a single E1 make
    always_comb begin
        dec_push = 1'b0;
        dec_ext  = ext_q;
        dec_rel  = 1'b0;
        dec_code = scan_code;
        if (scan_ready) begin
            case (state_q)
                ST_IDLE: begin
                    dec_push = !(is_e0 || is_f0 || is_e1 || is_status);
                    dec_ext  = 1'b0;
                end
                ST_EXT: begin
                    dec_push = !(is_f0 || is_e0 || is_fake);
                    dec_ext  = 1'b1;
                end
                ST_BRK: begin
                    dec_push = !(is_f0 || is_e0) && !(ext_q && is_fake);
                    dec_rel  = 1'b1;
                end
                default: begin
                    dec_push = skip_q == 3'd1;
                    dec_ext  = 1'b1;
                    dec_code = 8'hE1;
                end
            endcase
        end
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       last_vld_q, last_vld_d;
    logic [8:0] last_key_q, last_key_d;
    logic       same_key;

    always_comb begin
        same_key   = last_vld_q && last_key_q == {dec_ext, dec_code};
        push       = dec_push && (dec_rel || !same_key);
        last_vld_d = last_vld_q;
        last_key_d = last_key_q;
        if (dec_push && !dec_rel && !same_key) begin
            last_vld_d = 1'b1;
            last_key_d = {dec_ext, dec_code};
        end else if (dec_push && dec_rel && same_key) begin
            last_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_vld_q <= 1'b0;
            last_key_q <= 9'd0;
        end else begin
            last_vld_q <= last_vld_d;
            last_key_q <= last_key_d;
        end
    end
`else
    assign push = dec_push;
`endif

    // A full FIFO still accepts a push when the head is popped in the same cycle
    assign pop  = count_q != '0 && ev_ready;
    assign full = count_q == (DEPTH_LOG2+1)'(DEPTH);
    assign wr   = push && (!full || pop);
    assign drop = push && full && !pop;

    always_comb begin
        wr_ptr_d = wr ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
        ovf_d    = ovf_q || drop;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {dec_ext, dec_rel, dec_code};
    end

    assign head       = mem_q[rd_ptr_q];
    assign ev_valid   = count_q != '0;
    assign ev_code    = ev_valid ? head[7:0] : 8'd0;
    assign ev_release = ev_valid && head[8];
    assign ev_ext     = ev_valid && head[9];
    assign ev_count   = count_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_ps2_event_decoder.sv
// tb_ps2_event_decoder: directed and random stimulus against a pending-byte-queue reference model.
module tb_ps2_event_decoder;
    localparam int DL = 3;
    localparam int DEPTH = 1 << DL;

    logic          clk, reset, scan_ready, ev_ready;
    logic [7:0]    scan_code;
    logic          ev_valid, ev_ext, ev_release, overflow;
    logic [7:0]    ev_code;
    logic [DL:0]   ev_count;
    int            checks = 0;
    int            errors = 0;

    ps2_event_decoder #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .reset(reset), .scan_ready(scan_ready), .scan_code(scan_code),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
        .ev_release(ev_release), .ev_count(ev_count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes of an unfinished sequence are kept verbatim and interpreted on arrival
    logic [7:0] pend[$];
    logic [9:0] mq[$];
    bit         movf;
    bit         lv;
    logic [8:0] lm;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend.delete();
            mq.delete();
            movf = 0;
            lv   = 0;
        end else begin
            automatic bit         ph = 0;
            automatic logic [9:0] ev = '0;
            automatic logic [7:0] b = scan_code;
            automatic bit         popm = mq.size() > 0 && ev_ready;
            if (scan_ready) begin
                if (pend.size() == 0) begin
                    if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
                    else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
                        ph = 1;
                        ev = {2'b00, b};
                    end
                end else if (pend[0] == 8'hE1) begin
                    pend.push_back(b);
                    if (pend.size() == 8) begin
                        ph = 1;
                        ev = {2'b10, 8'hE1};
                        pend.delete();
                    end
                end else if (b == 8'hE0 || b == 8'hF0) begin
                    pend.push_back(b);
                end else begin
                    automatic bit ext = pend[0] == 8'hE0;
                    automatic bit brk = 0;
                    foreach (pend[i]) if (pend[i] == 8'hF0) brk = 1;
                    pend.delete();
                    if (!(ext && (b == 8'h12 || b == 8'h59))) begin
                        ph = 1;
                        ev = {ext, brk, b};
                    end
                end
            end
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (ph && !ev[8]) begin
                if (lv && lm == {ev[9], ev[7:0]}) ph = 0;
                else begin
                    lv = 1;
                    lm = {ev[9], ev[7:0]};
                end
            end else if (ph && ev[8] && lv && lm == {ev[9], ev[7:0]}) lv = 0;
`endif
            if (popm) void'(mq.pop_front());
            if (ph) begin
                if (mq.size() < DEPTH) mq.push_back(ev);
                else movf = 1;
            end
        end
    end

    always @(negedge clk) begin
        automatic logic [9:0] h = mq.size() > 0 ? mq[0] : 10'd0;
        chk("m_valid", ev_valid, mq.size() > 0);
        chk("m_code", ev_code, h[7:0]);
        chk("m_ext", ev_ext, h[9]);
        chk("m_rel", ev_release, h[8]);
        chk("m_count", ev_count, mq.size());
        chk("m_ovf", overflow, movf);
    end

    task automatic strobe(input logic [7:0] b);
        @(negedge clk); #1;
        scan_ready = 1'b1;
        scan_code  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            scan_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        scan_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ev_valid) break;
            n++;
            ev_ready = 1'b1;
            @(negedge clk); #1;
            ev_ready = 1'b0;
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] code);
        chk(name, ev_code, code);
        ev_ready = 1'b1;
        @(negedge clk); #1;
        ev_ready = 1'b0;
    endtask

    logic [7:0] pool [14] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'hAA, 8'hFA,
                              8'h00, 8'hFF, 8'h1C, 8'h74, 8'h14, 8'h77, 8'h1C};

    initial begin
        int n;
        reset = 1'b1; scan_ready = 1'b0; scan_code = 8'h00; ev_ready = 1'b0;
        #1 reset = 1'b0;
        idle(2);
        reset = 1'b1;
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", ev_count, 0);
        chk("rst_ovf", overflow, 0);

        strobe(8'h1C); idle(1);
        chk("mk_valid", ev_valid, 1);
        chk("mk_code", ev_code, 8'h1C);
        chk("mk_flags", {ev_ext, ev_release}, 2'b00);
        chk("mk_count", ev_count, 1);
        drain(n);

        strobe(8'hE0); strobe(8'hF0); strobe(8'h74); idle(1);
        chk("ebrk_code", ev_code, 8'h74);
        chk("ebrk_flags", {ev_ext, ev_release}, 2'b11);
        drain(n);
        chk("ebrk_n", n, 1);

        strobe(8'hE0); strobe(8'h12); strobe(8'hAA); idle(2);
        chk("fake_none", ev_count, 0);

        do_reset();
        for (int i = 0; i < 9; i++) strobe(8'h15 + 8'(i));
        idle(1);
        chk("ovf_count", ev_count, 8);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) pop_check("ovf_order", 8'h15 + 8'(i));
        chk("ovf_sticky", overflow, 1);
        chk("ovf_empty", ev_valid, 0);

        do_reset();
        for (int i = 0; i < 8; i++) strobe(8'h15 + 8'(i));
        strobe(8'h2D);
        ev_ready = 1'b1;
        idle(1);
        ev_ready = 1'b0;
        chk("fp_count", ev_count, 8);
        chk("fp_ovf", overflow, 0);
        for (int i = 1; i < 8; i++) pop_check("fp_order", 8'h15 + 8'(i));
        pop_check("fp_last", 8'h2D);

        do_reset();
        foreach (pool[i]) if (i == 100) strobe(8'h00);
        strobe(8'hE1); strobe(8'h14); strobe(8'h77); strobe(8'hE1);
        strobe(8'hF0); strobe(8'h14); strobe(8'hF0); strobe(8'h77); idle(1);
        chk("pause_code", ev_code, 8'hE1);
        chk("pause_flags", {ev_ext, ev_release}, 2'b10);
        drain(n);
        chk("pause_n", n, 1);

        do_reset();
        strobe(8'h1C); strobe(8'h1C); strobe(8'h1C); strobe(8'hF0); strobe(8'h1C); idle(1);
`ifdef PS2_TYPEMATIC_FILTER_EN
        chk("typ_count", ev_count, 2);
`else
        chk("typ_count", ev_count, 4);
`endif
        drain(n);

        strobe(8'hE0); strobe(8'hF0); idle(1);
        do_reset();
        strobe(8'h74); idle(1);
        chk("abort_code", ev_code, 8'h74);
        chk("abort_flags", {ev_ext, ev_release}, 2'b00);
        chk("abort_count", ev_count, 1);
        drain(n);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk); #1;
            reset      = $urandom_range(0, 599) != 0;
            scan_ready = $urandom_range(0, 2) == 0;
            scan_code  = $urandom_range(0, 4) == 0 ? 8'($urandom) : pool[$urandom_range(0, 13)];
            ev_ready   = ((c / 300) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
        end
        @(negedge clk); #1;
        reset = 1'b1; scan_ready = 1'b0; ev_ready = 1'b1;
        idle(12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
